// File: rtl/rgmii_tx_framer.sv
// rtl/rgmii_tx_framer.sv - RGMII tx framer: preamble, SFD, payload, zero pad (TX_PAD_EN), CRC-32 FCS, IFG
// Emits one registered byte per clk125Tx cycle as rise/fall nibble and ctrl pairs for the ODDR stage.
module rgmii_tx_framer #(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int IFG_BYTES       = 12,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int MAX_FRAME_BYTES = 1514,
    parameter int CNT_W           = 16
) (
    input  logic             clkIn,
    input  logic             rstBIn,
    input  logic [7:0]       dataIn,
    input  logic             dataValidIn,
    input  logic             dataLastIn,
    output logic             dataReadyOut,
    output logic [3:0]       txDataRiseOut,
    output logic [3:0]       txDataFallOut,
    output logic             txCtrlRiseOut,
    output logic             txCtrlFallOut,
    output logic             busyOut,
    output logic [CNT_W-1:0] frameCountOut,
    output logic [CNT_W-1:0] errCountOut
);

    localparam int BC_W     = $clog2(MAX_FRAME_BYTES + 1);
    localparam int STEP_MAX = (PREAMBLE_BYTES > IFG_BYTES) ? PREAMBLE_BYTES : IFG_BYTES;
    localparam int SC_W     = $clog2(STEP_MAX + 4);
    localparam logic [SC_W-1:0] PRE_LAST = SC_W'(PREAMBLE_BYTES - 1);
    localparam logic [SC_W-1:0] FCS_LAST = SC_W'(3);
    // The IDLE cycle that samples the next dataValidIn is the last idle cycle of the gap
    localparam logic [SC_W-1:0] IFG_LAST = SC_W'(IFG_BYTES - 2);
    localparam logic [BC_W-1:0] BC_MAX   = BC_W'(MAX_FRAME_BYTES);
`ifdef TX_PAD_EN
    localparam logic [BC_W-1:0] BC_MIN_LAST = BC_W'(MIN_FRAME_BYTES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_PAYLOAD,
`ifdef TX_PAD_EN
        S_PAD,
`endif
        S_FCS,
        S_IFG
    } state_e;

    state_e            state_q, state_d;
    logic [SC_W-1:0]   step_q, step_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [31:0]       crc_q, crc_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d;
    logic              tx_er_q, tx_er_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              oversize;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Byte count saturates at MAX, so reaching it marks every further byte as oversize
    assign oversize = (bcnt_q == BC_MAX);

    always_ff @(posedge clkIn or negedge rstBIn) begin
        if (!rstBIn) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            bcnt_q      <= '0;
            crc_q       <= '1;
            tx_data_q   <= '0;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            bcnt_q      <= bcnt_d;
            crc_q       <= crc_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            tx_er_q     <= tx_er_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (dataValidIn) state_d = S_PRE;
            S_PRE:     if (step_q == PRE_LAST) state_d = S_SFD;
            S_SFD:     state_d = S_PAYLOAD;
            S_PAYLOAD: begin
                if (!dataValidIn || (dataLastIn && oversize)) begin
                    state_d = S_IFG;
                end else if (dataLastIn) begin
`ifdef TX_PAD_EN
                    state_d = (bcnt_q < BC_MIN_LAST) ? S_PAD : S_FCS;
`else
                    state_d = S_FCS;
`endif
                end
            end
`ifdef TX_PAD_EN
            S_PAD:     if (bcnt_q == BC_MIN_LAST) state_d = S_FCS;
`endif
            S_FCS:     if (step_q == FCS_LAST) state_d = S_IFG;
            S_IFG:     if (step_q == IFG_LAST) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dataReadyOut = (state_q == S_PAYLOAD);
        tx_data_d    = 8'h00;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        bcnt_d       = bcnt_q;
        crc_d        = crc_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;
        case (state_q)
            S_IDLE: begin
                bcnt_d = '0;
                crc_d  = '1;
            end
            S_PRE: begin
                tx_data_d = 8'h55;
                tx_en_d   = 1'b1;
            end
            S_SFD: begin
                tx_data_d = 8'hD5;
                tx_en_d   = 1'b1;
            end
            S_PAYLOAD: begin
                tx_en_d = 1'b1;
                if (dataValidIn) begin
                    tx_data_d = dataIn;
                    tx_er_d   = oversize;
                    crc_d     = crc_byte(crc_q, dataIn);
                    if (!oversize) bcnt_d = bcnt_q + BC_W'(1);
                    if (dataLastIn && oversize) err_cnt_d = sat_inc(err_cnt_q);
                end else begin
                    tx_er_d   = 1'b1;
                    err_cnt_d = sat_inc(err_cnt_q);
                end
            end
`ifdef TX_PAD_EN
            S_PAD: begin
                tx_en_d = 1'b1;
                crc_d   = crc_byte(crc_q, 8'h00);
                bcnt_d  = bcnt_q + BC_W'(1);
            end
`endif
            S_FCS: begin
                tx_data_d = ~crc_q[7:0];
                tx_en_d   = 1'b1;
                crc_d     = {8'hFF, crc_q[31:8]};
                if (step_q == FCS_LAST) frame_cnt_d = sat_inc(frame_cnt_q);
            end
            default: ;
        endcase
        step_d = (state_d == state_q) ? step_q + SC_W'(1) : '0;
    end

    assign txDataRiseOut = tx_data_q[3:0];
    assign txDataFallOut = tx_data_q[7:4];
    assign txCtrlRiseOut = tx_en_q;
    assign txCtrlFallOut = tx_en_q ^ tx_er_q;
    assign busyOut       = (state_q != S_IDLE);
    assign frameCountOut = frame_cnt_q;
    assign errCountOut   = err_cnt_q;

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// tb/tb_rgmii_tx_framer.sv - scoreboard bench for rgmii_tx_framer with a queue-based frame model
module tb_rgmii_tx_framer;

    localparam int PRE  = 7;
    localparam int IFG  = 12;
    localparam int MINF = 60;
    localparam int MAXF = 1514;

    logic        clkIn = 1'b0;
    logic        rstBIn = 1'b1;
    logic [7:0]  dataIn = 8'h00;
    logic        dataValidIn = 1'b0;
    logic        dataLastIn = 1'b0;
    logic        dataReadyOut;
    logic [3:0]  txDataRiseOut, txDataFallOut;
    logic        txCtrlRiseOut, txCtrlFallOut, busyOut;
    logic [15:0] frameCountOut, errCountOut;

    rgmii_tx_framer dut (
        .clkIn         (clkIn),
        .rstBIn        (rstBIn),
        .dataIn        (dataIn),
        .dataValidIn   (dataValidIn),
        .dataLastIn    (dataLastIn),
        .dataReadyOut  (dataReadyOut),
        .txDataRiseOut (txDataRiseOut),
        .txDataFallOut (txDataFallOut),
        .txCtrlRiseOut (txCtrlRiseOut),
        .txCtrlFallOut (txCtrlFallOut),
        .busyOut       (busyOut),
        .frameCountOut (frameCountOut),
        .errCountOut   (errCountOut)
    );

    always #4 clkIn = ~clkIn;

    typedef struct {
        logic [7:0] d;
        bit         er;
        bit         endf;
        int         fc;
        int         ec;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  pay[$];
    logic [31:0] crc_tab[256];
    int          checks = 0;
    int          errors = 0;
    int          model_fc = 0;
    int          model_ec = 0;

    function automatic logic [31:0] crc_of(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (q[i]) c = crc_tab[(c ^ {24'h0, q[i]}) & 32'hFF] ^ (c >> 8);
        return c;
    endfunction

    task automatic build_table();
        for (int n = 0; n < 256; n++) begin
            logic [31:0] v = n;
            for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
            crc_tab[n] = v;
        end
    endtask

    task automatic add(input logic [7:0] d, input bit er);
        exp_t e;
        e.d = d; e.er = er; e.endf = 0; e.fc = 0; e.ec = 0;
        exp_q.push_back(e);
    endtask

    task automatic close_frame();
        exp_t e;
        e = exp_q.pop_back();
        e.endf = 1; e.fc = model_fc; e.ec = model_ec;
        exp_q.push_back(e);
    endtask

    // Expected line bytes for the frame in pay; cut>0 means dataValidIn drops after cut bytes
    task automatic expect_frame(input int cut);
        logic [7:0]  body[$];
        logic [31:0] fcs;
        int n;
        n = (cut > 0) ? cut : pay.size();
        for (int i = 0; i < PRE; i++) add(8'h55, 0);
        add(8'hD5, 0);
        for (int i = 0; i < n; i++) add(pay[i], i >= MAXF);
        if (cut > 0) begin
            model_ec++;
            add(8'h00, 1);
        end else if (pay.size() > MAXF) begin
            model_ec++;
        end else begin
            body = pay;
`ifdef TX_PAD_EN
            while (body.size() < MINF) begin
                body.push_back(8'h00);
                add(8'h00, 0);
            end
`endif
            fcs = ~crc_of(body);
            for (int i = 0; i < 4; i++) add(fcs[8*i +: 8], 0);
            model_fc++;
        end
        close_frame();
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit l);
        int t = 0;
        dataIn = b; dataValidIn = 1'b1; dataLastIn = l;
        while (!dataReadyOut && t < 300) begin
            @(negedge clkIn);
            t++;
        end
        if (t >= 300) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: ready=%b after %0d cycles, want 1", dataReadyOut, t);
        end
        @(negedge clkIn);
    endtask

    task automatic send_frame(input int cut);
        int n;
        expect_frame(cut);
        n = (cut > 0) ? cut : pay.size();
        for (int i = 0; i < n; i++) drive_byte(pay[i], (cut <= 0) && (i == n - 1));
        if (cut > 0) begin
            dataValidIn = 1'b0;
            dataLastIn  = 1'($urandom_range(0, 1));
            @(negedge clkIn);
        end
    endtask

    task automatic make_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic check_reset_outputs(input string name);
        logic [41:0] got;
        got = {dataReadyOut, txDataRiseOut, txDataFallOut, txCtrlRiseOut, txCtrlFallOut,
               busyOut, frameCountOut, errCountOut};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s: outputs=%h, want 0", name, got);
        end
    endtask

    // Monitor: pops one expected byte per TX_EN cycle; idle cycles must be all-zero
    initial begin
        exp_t e;
        int   gap = 0;
        bit   prev_en = 0;
        bit   gap_armed = 0;
        forever begin
            @(posedge clkIn);
            #1;
            if (!rstBIn) begin
                gap = 0; prev_en = 0; gap_armed = 0;
                continue;
            end
            if (txCtrlRiseOut) begin
                if (!prev_en && gap_armed) begin
                    checks++;
                    if (gap != IFG) begin
                        errors++;
                        $display("FAIL ifg_gap: got %0d idle cycles, want %0d", gap, IFG);
                    end
                end
                if (!prev_en) gap_armed = 0;
                gap = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %h with TX_EN=1, want no frame", {txDataFallOut, txDataRiseOut});
                end else begin
                    e = exp_q.pop_front();
                    if ({txDataFallOut, txDataRiseOut, txCtrlFallOut, busyOut} !== {e.d, ~e.er, 1'b1}) begin
                        errors++;
                        $display("FAIL line_byte: got data=%h fall_ctrl=%b busy=%b, want data=%h fall_ctrl=%b busy=1",
                                 {txDataFallOut, txDataRiseOut}, txCtrlFallOut, busyOut, e.d, ~e.er);
                    end
                    if (e.endf) begin
                        checks++;
                        if (frameCountOut !== 16'(e.fc) || errCountOut !== 16'(e.ec)) begin
                            errors++;
                            $display("FAIL counters: got frames=%0d errs=%0d, want frames=%0d errs=%0d",
                                     frameCountOut, errCountOut, e.fc, e.ec);
                        end
                        gap_armed = 1;
                    end
                end
            end else begin
                gap++;
                checks++;
                if ({txDataFallOut, txDataRiseOut, txCtrlFallOut} !== 9'h0) begin
                    errors++;
                    $display("FAIL idle_line: got data=%h fall_ctrl=%b, want 00/0",
                             {txDataFallOut, txDataRiseOut}, txCtrlFallOut);
                end
            end
            prev_en = txCtrlRiseOut;
        end
    end

    initial begin
        int n, cut, t;
        build_table();
        #2 rstBIn = 1'b0;
        #1 check_reset_outputs("reset_state");
        repeat (3) @(negedge clkIn);
        rstBIn = 1'b1;
        @(negedge clkIn);

        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
        send_frame(-1);
        make_random(64);   send_frame(-1);
        make_random(64);   send_frame(-1);
        make_random(30);   send_frame(20);
        make_random(1);    send_frame(-1);
        make_random(1600); send_frame(-1);
        make_random(1514); send_frame(-1);
        make_random(1515); send_frame(-1);
        for (int k = 0; k < 6; k++) begin
            n   = $urandom_range(2, 100);
            cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
            make_random(n);
            send_frame(cut);
        end

        // Reset in the middle of a payload
        make_random(40);
        expect_frame(-1);
        for (int i = 0; i < 10; i++) drive_byte(pay[i], 0);
        rstBIn = 1'b0;
        dataValidIn = 1'b0;
        exp_q.delete();
        model_fc = 0;
        model_ec = 0;
        #1 check_reset_outputs("mid_frame_reset");
        repeat (3) @(negedge clkIn);
        rstBIn = 1'b1;
        @(negedge clkIn);
        make_random(25); send_frame(-1);
        make_random(70); send_frame(-1);
        dataValidIn = 1'b0;

        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clkIn);
            t++;
        end
        repeat (16) @(negedge clkIn);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected bytes never seen, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
